// File: rtl/crosswalk_controller.sv
// Six-phase NS/EW intersection sequencer with a shared phase countdown and latched pedestrian walk grants.
// Registered outputs; timing advances only on tick, reset is synchronous and active-high.
module crosswalk_controller #(
  parameter int GREEN_TIME   = 60,
  parameter int YELLOW_TIME  = 4,
  parameter int ALL_RED_TIME = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ped_req_ns,
  input  logic       ped_req_ew,
  output logic [6:0] master_timer,
  output logic       walk_enable_ns,
  output logic       walk_enable_ew,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_B = 3'd5
  } state_e;

  localparam logic [6:0] L_GREEN_M1  = 7'(GREEN_TIME) - 7'd1;
  localparam logic [6:0] L_YELLOW_M1 = 7'(YELLOW_TIME) - 7'd1;
  localparam logic [6:0] L_ALLRED_M1 = 7'(ALL_RED_TIME) - 7'd1;
  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  logic [2:0] r_state;
  logic [6:0] r_timer;
  logic [2:0] r_ns_light;
  logic [2:0] r_ew_light;
  logic       r_pend_ns;
  logic       r_pend_ew;
  logic       r_serve_ns;
  logic       r_serve_ew;

  logic [2:0] w_next;
  logic [6:0] w_next_load;
  logic       w_illegal;
  logic       w_advance;
  logic       w_enter_ns;
  logic       w_enter_ew;
  logic       w_leave_ns;
  logic       w_leave_ew;

  always_comb begin
    w_next = ALL_RED_B;
    case (r_state)
      NS_GREEN:  w_next = NS_YELLOW;
      NS_YELLOW: w_next = ALL_RED_A;
      ALL_RED_A: w_next = EW_GREEN;
      EW_GREEN:  w_next = EW_YELLOW;
      EW_YELLOW: w_next = ALL_RED_B;
      ALL_RED_B: w_next = NS_GREEN;
      default:   w_next = ALL_RED_B;
    endcase
  end

  always_comb begin
    w_next_load = L_ALLRED_M1;
    case (w_next)
      NS_GREEN, EW_GREEN:   w_next_load = L_GREEN_M1;
      NS_YELLOW, EW_YELLOW: w_next_load = L_YELLOW_M1;
      default:              w_next_load = L_ALLRED_M1;
    endcase
  end

  assign w_illegal  = (r_state > ALL_RED_B);
  assign w_advance  = tick & (r_timer == 7'd0) & ~w_illegal;
  assign w_enter_ns = w_advance & (r_state == ALL_RED_B);
  assign w_enter_ew = w_advance & (r_state == ALL_RED_A);
  assign w_leave_ns = w_advance & (r_state == NS_GREEN);
  assign w_leave_ew = w_advance & (r_state == EW_GREEN);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ALL_RED_B;
      r_timer    <= L_ALLRED_M1;
      r_ns_light <= L_RED;
      r_ew_light <= L_RED;
      r_pend_ns  <= 1'b0;
      r_pend_ew  <= 1'b0;
      r_serve_ns <= 1'b0;
      r_serve_ew <= 1'b0;
    end else begin
      if (w_illegal) begin
        r_state    <= ALL_RED_B;
        r_timer    <= L_ALLRED_M1;
        r_ns_light <= L_RED;
        r_ew_light <= L_RED;
      end else if (w_advance) begin
        r_state    <= w_next;
        r_timer    <= w_next_load;
        r_ns_light <= (w_next == NS_GREEN)  ? L_GRN :
                      (w_next == NS_YELLOW) ? L_YEL : L_RED;
        r_ew_light <= (w_next == EW_GREEN)  ? L_GRN :
                      (w_next == EW_YELLOW) ? L_YEL : L_RED;
      end else if (tick) begin
        r_timer <= r_timer - 7'd1;
      end

      // A request while the direction is already walking is absorbed.
      if (w_enter_ns) begin
        r_serve_ns <= r_pend_ns | ped_req_ns;
        r_pend_ns  <= 1'b0;
      end else begin
        if (w_leave_ns || w_illegal) r_serve_ns <= 1'b0;
        if (ped_req_ns && !((r_state == NS_GREEN) && r_serve_ns)) r_pend_ns <= 1'b1;
      end

      if (w_enter_ew) begin
        r_serve_ew <= r_pend_ew | ped_req_ew;
        r_pend_ew  <= 1'b0;
      end else begin
        if (w_leave_ew || w_illegal) r_serve_ew <= 1'b0;
        if (ped_req_ew && !((r_state == EW_GREEN) && r_serve_ew)) r_pend_ew <= 1'b1;
      end
    end
  end

  assign phase          = r_state;
  assign master_timer   = r_timer;
  assign ns_light       = r_ns_light;
  assign ew_light       = r_ew_light;
  assign walk_enable_ns = r_serve_ns & (r_state == NS_GREEN);
  assign walk_enable_ew = r_serve_ew & (r_state == EW_GREEN);

endmodule

// File: tb/tb_crosswalk_controller.sv
// Bench for crosswalk_controller: directed scenarios plus random ticks/requests against a phase/tick-count model.
module tb_crosswalk_controller;
  localparam int G = 8;
  localparam int Y = 3;
  localparam int A = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       ped_req_ns = 1'b0;
  logic       ped_req_ew = 1'b0;
  logic [6:0] master_timer;
  logic       walk_enable_ns;
  logic       walk_enable_ew;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [2:0] phase;

  crosswalk_controller #(.GREEN_TIME(G), .YELLOW_TIME(Y), .ALL_RED_TIME(A)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew),
    .master_timer(master_timer),
    .walk_enable_ns(walk_enable_ns), .walk_enable_ew(walk_enable_ew),
    .ns_light(ns_light), .ew_light(ew_light), .phase(phase)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b1;
  bit force_ill = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: phase index plus ticks spent in it; walk grant decided at green entry.
  int m_phase = 5, m_cnt = 0;
  bit m_valid = 0, m_pend_ns = 0, m_pend_ew = 0, m_serve_ns = 0, m_serve_ew = 0;

  function automatic int dur(input int p);
    if (p == 0 || p == 3) return G;
    if (p == 1 || p == 4) return Y;
    return A;
  endfunction

  function automatic int ns_exp(input int p);
    return (p == 0) ? 1 : (p == 1) ? 2 : 4;
  endfunction

  function automatic int ew_exp(input int p);
    return (p == 3) ? 1 : (p == 4) ? 2 : 4;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 5; m_cnt = 0; m_valid = 1;
      m_pend_ns = 0; m_pend_ew = 0; m_serve_ns = 0; m_serve_ew = 0;
    end else if (m_valid) begin
      if (ped_req_ns && !(m_phase == 0 && m_serve_ns)) m_pend_ns = 1;
      if (ped_req_ew && !(m_phase == 3 && m_serve_ew)) m_pend_ew = 1;
      if (force_ill) begin
        m_phase = 5; m_cnt = 0; m_serve_ns = 0; m_serve_ew = 0;
      end else if (tick) begin
        if (m_cnt == dur(m_phase) - 1) begin
          m_serve_ns = 0;
          m_serve_ew = 0;
          m_phase = (m_phase + 1) % 6;
          m_cnt = 0;
          if (m_phase == 0) begin m_serve_ns = m_pend_ns; m_pend_ns = 0; end
          if (m_phase == 3) begin m_serve_ew = m_pend_ew; m_pend_ew = 0; end
        end else begin
          m_cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && m_valid) begin
      chk("phase", int'(phase), m_phase);
      chk("master_timer", int'(master_timer), dur(m_phase) - 1 - m_cnt);
      chk("ns_light", int'(ns_light), ns_exp(m_phase));
      chk("ew_light", int'(ew_light), ew_exp(m_phase));
      chk("walk_ns", int'(walk_enable_ns), (m_phase == 0 && m_serve_ns) ? 1 : 0);
      chk("walk_ew", int'(walk_enable_ew), (m_phase == 3 && m_serve_ew) ? 1 : 0);
      chk("walk_exclusive", int'(walk_enable_ns & walk_enable_ew), 0);
    end
  end

  task automatic step(input bit t, input bit rn, input bit re);
    tick = t; ped_req_ns = rn; ped_req_ew = re;
    @(posedge clk);
    #1;
    tick = 1'b0; ped_req_ns = 1'b0; ped_req_ew = 1'b0;
  endtask

  task automatic step_auto(input bit rn, input bit re, output bit t_out);
    t_out = (cyc % 4 == 3);
    cyc++;
    step(t_out, rn, re);
  endtask

  task automatic wait_phase(input int p, input int t);
    bit found = 0;
    bit tk;
    for (int i = 0; i < 2000; i++) begin
      if (int'(phase) == p && (t < 0 || int'(master_timer) == t)) begin
        found = 1;
        break;
      end
      step_auto(0, 0, tk);
    end
    chk("wait_phase_reached", int'(found), 1);
  endtask

  initial begin
    int dwell_exp[6] = '{8, 3, 2, 8, 3, 2};
    int next_exp[6]  = '{1, 2, 3, 4, 5, 0};
    int cnt;
    int prev;
    bit tk;

    reset = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    reset = 1'b0;
    chk("rst_phase", int'(phase), 5);
    chk("rst_timer", int'(master_timer), 1);
    chk("rst_ns_light", int'(ns_light), 4);
    chk("rst_ew_light", int'(ew_light), 4);
    chk("rst_walks", int'({walk_enable_ns, walk_enable_ew}), 0);

    repeat (8) step_auto(0, 0, tk);
    chk("first_green_phase", int'(phase), 0);
    chk("first_green_timer", int'(master_timer), 7);
    chk("first_green_ns", int'(ns_light), 1);

    for (int k = 0; k < 6; k++) begin
      cnt = 0;
      prev = int'(phase);
      for (int i = 0; i < 200 && int'(phase) == prev; i++) begin
        step_auto(0, 0, tk);
        if (tk) cnt++;
      end
      chk("dwell_ticks", cnt, dwell_exp[k]);
      chk("next_phase", int'(phase), next_exp[k]);
    end

    // NS request during EW green is served on the next NS green only.
    wait_phase(3, -1);
    step(0, 1, 0);
    wait_phase(0, -1);
    chk("ns_walk_granted", int'(walk_enable_ns), 1);
    cnt = 0;
    for (int i = 0; i < 200 && int'(phase) == 0; i++) begin
      prev = int'(walk_enable_ns);
      step_auto(0, 0, tk);
      if (tk && prev == 1) cnt++;
    end
    chk("ns_walk_ticks", cnt, 8);
    chk("ns_walk_off_in_yellow", int'(walk_enable_ns), 0);
    wait_phase(0, -1);
    chk("ns_walk_not_repeated", int'(walk_enable_ns), 0);
    step(0, 1, 0);
    chk("ns_req_in_green_not_current", int'(walk_enable_ns), 0);
    wait_phase(1, -1);
    wait_phase(0, -1);
    chk("ns_req_in_green_next", int'(walk_enable_ns), 1);

    // EW request on the exact entry edge.
    wait_phase(2, 0);
    step(1, 0, 1);
    chk("ew_entry_phase", int'(phase), 3);
    chk("ew_entry_walk", int'(walk_enable_ew), 1);
    wait_phase(4, -1);
    wait_phase(3, -1);
    chk("ew_entry_not_pending", int'(walk_enable_ew), 0);

    // Reset beats tick and requests, and clears a pending EW request.
    wait_phase(0, -1);
    step(0, 0, 1);
    wait_phase(0, 3);
    reset = 1'b1;
    step(1, 1, 1);
    reset = 1'b0;
    chk("midrst_phase", int'(phase), 5);
    chk("midrst_timer", int'(master_timer), 1);
    chk("midrst_lights", int'({ns_light, ew_light}), 6'b100100);
    chk("midrst_walks", int'({walk_enable_ns, walk_enable_ew}), 0);
    wait_phase(3, -1);
    chk("midrst_ew_pend_cleared", int'(walk_enable_ew), 0);

    // Tick held high, then frozen.
    wait_phase(0, -1);
    repeat (3) step(1, 0, 0);
    chk("fast_tick_timer", int'(master_timer), 4);
    repeat (20) step(0, 0, 0);
    chk("frozen_timer", int'(master_timer), 4);
    chk("frozen_phase", int'(phase), 0);

    // Illegal state recovery.
    chk_en = 1'b0;
    force dut.r_state = 3'd7;
    #2;
    release dut.r_state;
    force_ill = 1'b1;
    step(0, 0, 0);
    force_ill = 1'b0;
    chk_en = 1'b1;
    chk("illegal_to_allred", int'(phase), 5);
    chk("illegal_lights", int'({ns_light, ew_light}), 6'b100100);

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 699) == 0);
      step($urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0);
    end
    reset = 1'b0;
    step(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
